spi_ram_slave: RTL

Parametrised SPI-slave-plus-single-port-RAM block: a serial master on SS_n/MOSI/MISO writes and reads an on-chip memory using 2-bit opcoded frames. It is the generalised successor of the fixed 8-bit SPI/RAM pair. Address width, data width and depth are configurable. It adds frame/opcode checking and optional address auto-increment for streaming access. The serial pins are sampled synchronously on the system clock.

---
 rtl/spi_ram_pkg.sv | 25 ++
 rtl/spi_ram_mem.sv | 130 +++++++++++++
 rtl/spi_ram_slave.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI RAM slave.
// Optional feature macro: SPI_RAM_AUTOINC_EN (address auto-increment).
package spi_ram_pkg;

  // Serial front-end states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  // Frame opcodes, the two bits that follow the R/W bit.
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  // Bits that follow the R/W bit: two opcode bits plus the payload.
  function automatic int frame_len(input int pw);
    return pw + 2;
  endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port RAM with write/read address registers and read-pending flag.
// Optional feature macro: SPI_RAM_AUTOINC_EN (post-increment of both
// address registers, wrapping at MEM_DEPTH-1).
module spi_ram_mem
  import spi_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH+1:0] rx_data,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rd_pending
);

`ifdef SPI_RAM_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH still fits.
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_pending_q, rd_pending_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  mem_we;

  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] payload;
  logic                  wr_in_range;
  logic                  rd_in_range;

  assign op          = rx_data[DATA_WIDTH+1:DATA_WIDTH];
  assign payload     = rx_data[DATA_WIDTH-1:0];
  assign wr_in_range = ({1'b0, wr_addr_q} < DEPTH_W);
  assign rd_in_range = ({1'b0, rd_addr_q} < DEPTH_W);

  // Next address with wrap from the last word (or anything beyond it) to 0.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    if (a >= LAST_ADDR) begin
      return '0;
    end else begin
      return a + ADDR_WIDTH'(1);
    end
  endfunction

  // Decode one accepted frame into address, pending-flag and RAM actions.
  always_comb begin
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    rd_pending_d = rd_pending_q;
    dout_d       = dout_q;
    tx_valid_d   = 1'b0;
    mem_we       = 1'b0;
    if (rx_valid) begin
      case (op)
        OP_WR_ADDR: begin
          wr_addr_d = payload[ADDR_WIDTH-1:0];
        end
        OP_WR_DATA: begin
          mem_we = wr_in_range;
          if (AUTOINC) begin
            wr_addr_d = next_addr(wr_addr_q);
          end else begin
            wr_addr_d = wr_addr_q;
          end
        end
        OP_RD_ADDR: begin
          rd_addr_d    = payload[ADDR_WIDTH-1:0];
          rd_pending_d = 1'b1;
        end
        OP_RD_DATA: begin
          dout_d     = rd_in_range ? mem_q[rd_addr_q] : '0;
          tx_valid_d = 1'b1;
          if (AUTOINC) begin
            rd_addr_d    = next_addr(rd_addr_q);
            rd_pending_d = 1'b1;
          end else begin
            rd_pending_d = 1'b0;
          end
        end
        default: begin
          wr_addr_d = wr_addr_q;
        end
      endcase
    end else begin
      mem_we = 1'b0;
    end
  end

  // Control registers; RAM contents are deliberately left out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      rd_pending_q <= 1'b0;
      tx_valid_q   <= 1'b0;
      dout_q       <= '0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      rd_pending_q <= rd_pending_d;
      tx_valid_q   <= tx_valid_d;
      dout_q       <= dout_d;
    end
  end

  // RAM write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_addr_q] <= payload;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign dout       = dout_q;
  assign rd_pending = rd_pending_q;

endmodule

// File: rtl/spi_ram_slave.sv
// SPI slave front end (pins sampled on clk) driving an on-chip RAM.
// Frame: R/W bit, then {opcode[1:0], payload[DATA_WIDTH-1:0]}, MSB first.
// Optional feature macro: SPI_RAM_AUTOINC_EN (see spi_ram_mem).
module spi_ram_slave
  import spi_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  localparam int PW = DATA_WIDTH;
  localparam int FL = frame_len(PW);
  localparam int CW = $clog2(FL + 1);
  localparam int TW = $clog2(DATA_WIDTH + 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [PW:0]           shift_q, shift_d;
  logic                  done_q, done_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [PW+1:0]         rx_data_q, rx_data_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [TW-1:0]         tx_cnt_q, tx_cnt_d;
  logic                  tx_active_q, tx_active_d;
  logic                  miso_q, miso_d;

  logic                  mem_tx_valid;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  mem_rd_pending;

  logic [PW+1:0]         full_frame;
  logic [1:0]            frame_op;
  logic                  op_ok;

  // The bit arriving now completes the frame when the counter hits FL-1.
  assign full_frame = {shift_q, MOSI};
  assign frame_op   = full_frame[PW+1:PW];

  // Opcode must match the state chosen by the R/W bit and rd_pending.
  always_comb begin
    op_ok = 1'b0;
    case (state_q)
      WRITE:     op_ok = (frame_op[1] == 1'b0);
      READ_ADD:  op_ok = (frame_op == OP_RD_ADDR);
      READ_DATA: op_ok = (frame_op == OP_RD_DATA);
      default:   op_ok = 1'b0;
    endcase
  end

  // Next-state logic for the serial FSM, frame receiver and read shifter.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    done_d      = done_q;
    rx_valid_d  = 1'b0;
    rx_data_d   = rx_data_q;
    tx_shift_d  = tx_shift_q;
    tx_cnt_d    = tx_cnt_q;
    tx_active_d = tx_active_q;
    miso_d      = 1'b0;
    if (SS_n) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      done_d      = 1'b0;
      tx_active_d = 1'b0;
      tx_cnt_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = CHK_CMD;
          bit_cnt_d = '0;
          done_d    = 1'b0;
        end
        CHK_CMD: begin
          if (MOSI) begin
            state_d = mem_rd_pending ? READ_DATA : READ_ADD;
          end else begin
            state_d = WRITE;
          end
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (!done_q) begin
            shift_d   = full_frame[PW:0];
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (bit_cnt_q == CW'(FL - 1)) begin
              done_d     = 1'b1;
              rx_valid_d = op_ok;
              rx_data_d  = full_frame;
            end else begin
              done_d = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      // Shift the captured read word out, MSB first, then idle low.
      if ((state_q == READ_DATA) && mem_tx_valid) begin
        miso_d      = mem_dout[DATA_WIDTH-1];
        tx_shift_d  = mem_dout << 1;
        tx_cnt_d    = TW'(DATA_WIDTH - 1);
        tx_active_d = 1'b1;
      end else if (tx_active_q) begin
        if (tx_cnt_q != '0) begin
          miso_d     = tx_shift_q[DATA_WIDTH-1];
          tx_shift_d = tx_shift_q << 1;
          tx_cnt_d   = tx_cnt_q - TW'(1);
        end else begin
          miso_d      = 1'b0;
          tx_active_d = 1'b0;
        end
      end else begin
        miso_d = 1'b0;
      end
    end
  end

  // Serial FSM and front-end registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      done_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      tx_shift_q  <= '0;
      tx_cnt_q    <= '0;
      tx_active_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      tx_shift_q  <= tx_shift_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_active_q <= tx_active_d;
      miso_q      <= miso_d;
    end
  end

  spi_ram_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid_q),
    .rx_data   (rx_data_q),
    .tx_valid  (mem_tx_valid),
    .dout      (mem_dout),
    .rd_pending(mem_rd_pending)
  );

  assign MISO = miso_q;

endmodule
